stepper_move_ctrl: RTL and testbench
====================================

STEPPER_MOVE_CTRL -- requirements
Module: stepper_move_ctrl

Interface
REQ-001 Parameter PULSE_W, default 50: step high time in clk_clk cycles, minimum 1.
REQ-002 Parameter DIR_SETUP, default 100: cycles from dir settling to the first step rise, minimum 1.
REQ-003 clk_clk  in  1  single clock, all logic on its rising edge; reset_reset  in  1  synchronous, active-high reset.
REQ-004 cmd_steps  in  32  move command: bit31 = direction (1 = positive), bits[30:0] = step count.
REQ-005 cmd_period  in  32  step period in clk_clk cycles.
REQ-006 start  in  1  level from the HPS flag PIO; a 0->1 transition requests a move.
REQ-007 abort  in  1  level; while high, any move in progress is stopped.
REQ-008 endstop  in  1  asynchronous endstop level, active-high.
REQ-009 step  out  1  step pulse to the driver.
REQ-010 dir  out  1  direction to the driver.
REQ-011 steps_done  out  32  steps issued in the current or last move, zero-extended.
REQ-012 busy  out  1  move in progress.
REQ-013 done  out  1  sticky: last move completed normally.
REQ-014 stopped  out  1  sticky: last move ended by abort or endstop.

Function
REQ-015 The endstop input shall pass through a 2-flop synchronizer before use; start shall be registered once for edge detection.
REQ-016 The state machine shall have the states IDLE, SETUP, HIGH, LOW.
REQ-017 A start rise detected in IDLE shall, on the next edge, latch the command, set dir = cmd_steps[31], clear steps_done, done and stopped, set busy, and enter SETUP.
REQ-018 A start rise while busy shall be ignored; the latched command shall not change.
REQ-019 A command with count 0 shall go directly from IDLE to IDLE with done=1 and busy=0, and shall produce no step pulse.
REQ-020 SETUP shall last DIR_SETUP cycles, then enter HIGH.
REQ-021 On entry to HIGH, step shall go 1 and steps_done shall increment. HIGH shall last PULSE_W cycles, then enter LOW with step=0.
REQ-022 LOW shall last (effective period - PULSE_W) cycles. Then:
 - if steps_done equals the count: enter IDLE, busy=0, done=1;
 - otherwise: enter HIGH.
REQ-023 Effective period = max(cmd_period, 2*PULSE_W). Periods 0 and 1 are clamped the same way.
REQ-024 The interval between step rises shall equal the effective period exactly.
REQ-025 A 32-bit cycle counter shall time every state; it shall not wrap within a state.
REQ-026 If abort is high in SETUP, HIGH or LOW: step=0 on the next edge, state IDLE, busy=0, stopped=1, done=0. steps_done shall keep its value.
REQ-027 Abort shall take priority over completion and over the endstop stop when they occur in the same cycle.
REQ-028 dir shall hold its value in IDLE and change only on an accepted start.

Reset
REQ-029 While reset_reset=1, on each edge: state IDLE; step, dir, busy, done, stopped = 0; steps_done = 0; synchronizer and edge-detect flops = 0.
REQ-030 Reset mid-move shall end the pulse within one cycle.
REQ-031 After reset is released, a start level that is already high shall not be treated as a rise.

Configuration
REQ-032 Macro STEPPER_ENDSTOP_STOP_EN.
 - Defined: a synchronized endstop=1 in SETUP or LOW shall end the move exactly as abort does (stopped=1). In HIGH, the pulse shall complete before the stop is taken in LOW.
 - Undefined: endstop shall be ignored (the synchronizer may be removed); behaviour is otherwise identical.

Verification
REQ-033 PULSE_W=2, DIR_SETUP=3, cmd_steps=0x80000004, cmd_period=10, start rise: dir=1 next cycle; 4 pulses, each 2 cycles high, 10 cycles rise-to-rise; then steps_done=4, done=1, busy=0.
REQ-034 cmd_period=1, PULSE_W=2, 3 steps: rise-to-rise spacing of 4 cycles.
REQ-035 cmd_steps=0: no step pulse; done=1 within 2 cycles of the start rise.
REQ-036 Abort raised during the HIGH of the 3rd step of 10: step low next cycle; busy=0, stopped=1, steps_done=3. A second start rise while busy is ignored.
REQ-037 With STEPPER_ENDSTOP_STOP_EN defined, endstop rises during LOW after step 5: move ends, stopped=1, steps_done=5. With the macro undefined, all 10 steps complete and done=1.
REQ-038 Reset asserted during HIGH with start held high: all outputs 0; no new move starts after release until start goes low and then high again.

Source files
------------

// File: rtl/stepper_move_ctrl.sv
// Stepper move controller: dir setup, then a fixed number of step pulses at a clamped period.
// Optional STEPPER_ENDSTOP_STOP_EN: a synchronized endstop ends the move like abort does.
module stepper_move_ctrl #(
  parameter int unsigned PULSE_W   = 50,
  parameter int unsigned DIR_SETUP = 100
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [31:0] cmd_steps,
  input  logic [31:0] cmd_period,
  input  logic        start,
  input  logic        abort,
  input  logic        endstop,
  output logic        step,
  output logic        dir,
  output logic [31:0] steps_done,
  output logic        busy,
  output logic        done,
  output logic        stopped
);

`ifdef STEPPER_ENDSTOP_STOP_EN
  localparam logic ES_EN = 1'b1;
`else
  localparam logic ES_EN = 1'b0;
`endif

  localparam logic [31:0] PW_C       = 32'(PULSE_W);
  localparam logic [31:0] MIN_PER    = 32'(2 * PULSE_W);
  localparam logic [31:0] SETUP_LAST = 32'(DIR_SETUP - 1);
  localparam logic [31:0] HIGH_LAST  = 32'(PULSE_W - 1);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [30:0] count_q, count_d;
  logic [31:0] low_last_q, low_last_d;
  logic [31:0] sd_q, sd_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        stopped_q, stopped_d;
  logic        start_q, arm_q;
  logic        es_meta_q, es_sync_q;

  logic [31:0] eff_s;
  logic [31:0] cnt_inc_s;
  logic        rise_s;
  logic        es_stop_s;

  // arm_q blocks a start level that was already high when reset released
  assign rise_s    = start & ~start_q & arm_q;
  assign eff_s     = (cmd_period < MIN_PER) ? MIN_PER : cmd_period;
  assign cnt_inc_s = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
  assign es_stop_s = ES_EN & es_sync_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_inc_s;
    count_d    = count_q;
    low_last_d = low_last_q;
    sd_d       = sd_q;
    step_d     = step_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    done_d     = done_q;
    stopped_d  = stopped_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'd0;
        if (rise_s) begin
          dir_d      = cmd_steps[31];
          count_d    = cmd_steps[30:0];
          low_last_d = eff_s - PW_C - 32'd1;
          sd_d       = 32'd0;
          stopped_d  = 1'b0;
          if (cmd_steps[30:0] == 31'd0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            done_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SETUP, HIGH, LOW: begin
        // abort outranks completion and endstop; endstop is deferred while the pulse is high
        if (abort || (es_stop_s && state_q != HIGH)) begin
          state_d   = IDLE;
          step_d    = 1'b0;
          busy_d    = 1'b0;
          stopped_d = 1'b1;
          done_d    = 1'b0;
          cnt_d     = 32'd0;
        end else if (state_q == SETUP && cnt_q == SETUP_LAST) begin
          state_d = HIGH;
          step_d  = 1'b1;
          sd_d    = sd_q + 32'd1;
          cnt_d   = 32'd0;
        end else if (state_q == HIGH && cnt_q == HIGH_LAST) begin
          state_d = LOW;
          step_d  = 1'b0;
          cnt_d   = 32'd0;
        end else if (state_q == LOW && cnt_q == low_last_q) begin
          cnt_d = 32'd0;
          if (sd_q == {1'b0, count_q}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = HIGH;
            step_d  = 1'b1;
            sd_d    = sd_q + 32'd1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
        step_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= IDLE;
      cnt_q      <= 32'd0;
      count_q    <= 31'd0;
      low_last_q <= 32'd0;
      sd_q       <= 32'd0;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stopped_q  <= 1'b0;
      start_q    <= 1'b0;
      arm_q      <= 1'b0;
      es_meta_q  <= 1'b0;
      es_sync_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      count_q    <= count_d;
      low_last_q <= low_last_d;
      sd_q       <= sd_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      stopped_q  <= stopped_d;
      start_q    <= start;
      arm_q      <= arm_q | ~start;
      es_meta_q  <= endstop;
      es_sync_q  <= es_meta_q;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign steps_done = sd_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign stopped    = stopped_q;

endmodule

// File: tb/tb_stepper_move_ctrl.sv
// Scoreboard bench for stepper_move_ctrl with PULSE_W=2, DIR_SETUP=3.
module tb_stepper_move_ctrl;
  logic        clk = 1'b0;
  logic        reset_reset;
  logic [31:0] cmd_steps, cmd_period;
  logic        start, abort, endstop;
  logic        step, dir, busy, done, stopped;
  logic [31:0] steps_done;

  stepper_move_ctrl #(.PULSE_W(2), .DIR_SETUP(3)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .cmd_steps(cmd_steps),
    .cmd_period(cmd_period), .start(start), .abort(abort), .endstop(endstop),
    .step(step), .dir(dir), .steps_done(steps_done), .busy(busy),
    .done(done), .stopped(stopped));

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int sd;
    bit exp_done;
    bit exp_stopped;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  int   total_pulses = 0;
  int   move_rises = 0;
  int   last_rise = 0;
  int   high_len = 0;
  logic prev_step = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: rise-to-rise spacing and high time against the active expectation
  always @(negedge clk) begin
    if (reset_reset) begin
      move_rises = 0;
      high_len   = 0;
    end else begin
      if (step && !prev_step) begin
        total_pulses++;
        if (sbq.size() == 0) check_eq("unexpected_step", {31'd0, step}, 32'd0);
        else if (move_rises > 0) check_eq("rise_period", cyc - last_rise, sbq[0].period);
        move_rises++;
        last_rise = cyc;
        high_len  = 1;
      end else if (step) begin
        high_len++;
      end else if (prev_step && busy) begin
        check_eq("pulse_width", high_len, 32'd2);
      end
      if (!busy) move_rises = 0;
    end
    prev_step = step;
  end

  task automatic push_exp(input logic [31:0] p, input int sd, input bit d, input bit s);
    exp_t e;
    e.period = (p < 32'd4) ? 4 : int'(p);
    e.sd = sd; e.exp_done = d; e.exp_stopped = s;
    sbq.push_back(e);
  endtask

  task automatic begin_move(input logic [31:0] s, input logic [31:0] p);
    start = 1'b0;
    @(negedge clk); @(negedge clk);
    cmd_steps = s; cmd_period = p;
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("dir_after_start", {31'd0, dir}, {31'd0, s[31]});
    check_eq("busy_after_start", {31'd0, busy}, {31'd0, (s[30:0] != 31'd0)});
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && busy; k++) @(negedge clk);
    check_eq("move_ends", {31'd0, busy}, 32'd0);
  endtask

  task automatic finish_move(input int base);
    exp_t e;
    e = sbq.pop_front();
    check_eq("steps_done", steps_done, e.sd);
    check_eq("done", {31'd0, done}, {31'd0, e.exp_done});
    check_eq("stopped", {31'd0, stopped}, {31'd0, e.exp_stopped});
    check_eq("pulse_count", total_pulses - base, e.sd);
  endtask

  task automatic run_move(input logic [31:0] s, input logic [31:0] p);
    int base;
    push_exp(p, int'(s[30:0]), 1'b1, 1'b0);
    base = total_pulses;
    begin_move(s, p);
    if (s[30:0] == 31'd0) check_eq("zero_done_fast", {31'd0, done}, 32'd1);
    wait_idle(3000);
    start = 1'b0;
    finish_move(base);
  endtask

  initial begin
    int base;
    reset_reset = 1'b1; start = 1'b0; abort = 1'b0; endstop = 1'b0;
    cmd_steps = 32'd0; cmd_period = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {26'd0, step, dir, busy, done, stopped, 1'b0}, 32'd0);
    check_eq("rst_steps_done", steps_done, 32'd0);
    reset_reset = 1'b0;

    run_move(32'h8000_0004, 32'd10);
    run_move(32'h0000_0003, 32'd1);
    run_move(32'h8000_0002, 32'd0);
    run_move(32'h8000_0000, 32'd10);
    run_move(32'h0000_0003, 32'd7);
    run_move(32'h8000_0003, 32'd5);

    // Abort during the 3rd pulse, with an ignored second start while busy
    push_exp(32'd10, 3, 1'b0, 1'b1);
    base = total_pulses;
    begin_move(32'h8000_000A, 32'd10);
    repeat (5) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cmd_steps = 32'h0000_0002; cmd_period = 32'd4; start = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2000 && !((total_pulses - base == 3) && step); k++) @(negedge clk);
    check_eq("abort_reach", {31'd0, step}, 32'd1);
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("abort_step_low", {31'd0, step}, 32'd0);
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_dir_held", {31'd0, dir}, 32'd1);
    abort = 1'b0; start = 1'b0;
    finish_move(base);

    // Endstop in LOW after step 5
`ifdef STEPPER_ENDSTOP_STOP_EN
    push_exp(32'd10, 5, 1'b0, 1'b1);
`else
    push_exp(32'd10, 10, 1'b1, 1'b0);
`endif
    base = total_pulses;
    begin_move(32'h0000_000A, 32'd10);
    for (int k = 0; k < 2000 && !((total_pulses - base == 5) && !step); k++) @(negedge clk);
    check_eq("endstop_reach", total_pulses - base, 32'd5);
    endstop = 1'b1;
    wait_idle(3000);
    endstop = 1'b0; start = 1'b0;
    finish_move(base);
    repeat (3) @(negedge clk);

    // Reset during HIGH with start held high
    push_exp(32'd10, 0, 1'b0, 1'b0);
    base = total_pulses;
    begin_move(32'h8000_0005, 32'd10);
    for (int k = 0; k < 2000 && !((total_pulses - base == 2) && step); k++) @(negedge clk);
    check_eq("reset_reach", {31'd0, step}, 32'd1);
    reset_reset = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_outs", {26'd0, step, dir, busy, done, stopped, 1'b0}, 32'd0);
    check_eq("midrst_steps_done", steps_done, 32'd0);
    void'(sbq.pop_front());
    repeat (2) @(negedge clk);
    reset_reset = 1'b0;
    base = total_pulses;
    repeat (20) @(negedge clk);
    check_eq("no_restart_busy", {31'd0, busy}, 32'd0);
    check_eq("no_restart_pulses", total_pulses - base, 32'd0);
    run_move(32'h8000_0002, 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
